// File: rtl/aes_framer_pkg.sv
// Shared definitions for the AES UART command framer: frame geometry,
// opcode byte values, FSM state encoding and an opcode-recognition helper.
package aes_framer_pkg;

    localparam int FRAME_BITS = 144;

    // Opcode byte values (ASCII)
    localparam logic [7:0] OP_TEST  = 8'h41; // "A"
    localparam logic [7:0] OP_KEY   = 8'h43; // "C"
    localparam logic [7:0] OP_TEXT  = 8'h44; // "D"
    localparam logic [7:0] OP_ENC   = 8'h45; // "E"
    localparam logic [7:0] OP_RES   = 8'h40; // "@"
    localparam logic [7:0] OP_RDKEY = 8'h61; // "a"
    localparam logic [7:0] OP_RDTXT = 8'h62; // "b"

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        EXEC  = 2'd3
    } fsm_state_t;

    // True when the byte is one of the supported opcodes
    function automatic logic op_known(input logic [7:0] op);
        logic known_v;
        case (op)
            OP_TEST, OP_KEY, OP_TEXT, OP_ENC,
            OP_RES, OP_RDKEY, OP_RDTXT: known_v = 1'b1;
            default:                    known_v = 1'b0;
        endcase
        return known_v;
    endfunction

endpackage

// File: rtl/aes_uart_cmd_framer_assembler.sv
// frame_shift_assembler: collects UART RX bytes into 144-bit frames.
// Bytes shift in at the bottom, so the first byte of a frame ends up in
// [143:136]. The completed frame is snapshotted so that bytes of the next
// frame can keep shifting in while the opcode FSM still works on it.
// Optional macro AES_FRAMER_TIMEOUT_EN: an inter-byte gap counter aborts a
// partial frame after TIMEOUT_CYCLES idle cycles.
module frame_shift_assembler
    import aes_framer_pkg::*;
#(
    parameter int FRAME_BYTES    = 18,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  pending,
    output logic                  timeout
);

    localparam logic [4:0] IDX_LAST = 5'(FRAME_BYTES - 1);

    logic [4:0]            idx_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [FRAME_BITS-1:0] frame_r;
    logic                  done_s;
    logic                  timeout_s;

    assign done_s = rx_valid && (idx_r == IDX_LAST);

`ifdef AES_FRAMER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap_r;

    // Abort once the partial frame has seen TIMEOUT_CYCLES idle cycles
    assign timeout_s = !rx_valid && (idx_r != 5'd0) && (gap_r == GAP_LAST);

    // Inter-byte gap counter: restarts on every byte, idles with no partial frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_r <= {GAP_W{1'b0}};
        end else if (rx_valid || (idx_r == 5'd0) || timeout_s) begin
            gap_r <= {GAP_W{1'b0}};
        end else begin
            gap_r <= gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
        end
    end
`else
    // No gap supervision: a partial frame waits until more bytes or reset.
    // TIMEOUT_CYCLES is referenced only so the parameter stays part of the interface.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Byte index within the current frame; wraps after the last byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= 5'd0;
        end else if (rx_valid) begin
            if (idx_r == IDX_LAST) begin
                idx_r <= 5'd0;
            end else begin
                idx_r <= idx_r + 5'd1;
            end
        end else if (timeout_s) begin
            idx_r <= 5'd0;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Byte shift register, newest byte at the bottom
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= {FRAME_BITS{1'b0}};
        end else if (rx_valid) begin
            shift_r <= {shift_r[FRAME_BITS-9:0], rx_data};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Snapshot of the last completed frame, stable while the next one arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_r <= {FRAME_BITS{1'b0}};
        end else if (done_s) begin
            frame_r <= {shift_r[FRAME_BITS-9:0], rx_data};
        end else begin
            frame_r <= frame_r;
        end
    end

    assign frame_done = done_s;
    assign frame      = frame_r;
    assign pending    = (idx_r != 5'd0);
    assign timeout    = timeout_s;

endmodule

// File: rtl/aes_uart_cmd_framer.sv
// aes_uart_cmd_framer: command front end between the UART byte stream and
// the AES-128 encrypt core. Validates 18-byte command frames, drives the
// key/plaintext/load interface of the core, captures its result and builds
// 18-byte reply frames for the UART TX path.
// Optional macro AES_FRAMER_TIMEOUT_EN enables the partial-frame timeout.
module aes_uart_cmd_framer
    import aes_framer_pkg::*;
#(
    parameter int                    FRAME_BYTES    = 18,
    parameter int                    TIMEOUT_CYCLES = 1_000_000,
    parameter logic [FRAME_BITS-1:0] TEST_PATTERN   = 144'h313233343536373839303132333435363738
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [127:0]          key,
    output logic [127:0]          text,
    output logic                  aes_ld,
    input  logic                  aes_done,
    input  logic [127:0]          aes_result,
    output logic [FRAME_BITS-1:0] tx_frame,
    output logic                  tx_send,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    fsm_state_t state_r;
    fsm_state_t state_next_s;

    logic                  frame_done_s;
    logic                  pending_s;
    logic                  timeout_s;
    logic [FRAME_BITS-1:0] frame_s;

    logic [7:0]   op_s;
    logic [7:0]   trailer_s;
    logic [127:0] payload_s;
    logic         frame_ok_s;
    logic [127:0] result_fwd_s;

    logic                  key_wr_s;
    logic                  text_wr_s;
    logic                  ld_req_s;
    logic                  reply_s;
    logic                  err_chk_s;
    logic                  err_enc_s;
    logic                  err_inc_s;
    logic [FRAME_BITS-1:0] reply_frame_s;

    logic [127:0]          key_r;
    logic [127:0]          text_r;
    logic [127:0]          result_r;
    logic                  busy_r;
    logic                  aes_ld_r;
    logic                  tx_send_r;
    logic [FRAME_BITS-1:0] tx_frame_r;
    logic [7:0]            err_cnt_r;

    frame_shift_assembler #(
        .FRAME_BYTES    (FRAME_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_done (frame_done_s),
        .frame      (frame_s),
        .pending    (pending_s),
        .timeout    (timeout_s)
    );

    assign op_s         = frame_s[143:136];
    assign payload_s    = frame_s[135:8];
    assign trailer_s    = frame_s[7:0];
    assign frame_ok_s   = (op_s == trailer_s) && op_known(op_s);
    // A result arriving in the same cycle as a read-back is forwarded
    assign result_fwd_s = aes_done ? aes_result : result_r;
    assign err_inc_s    = err_chk_s | err_enc_s | timeout_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a byte taken during CHECK/EXEC resumes reception from IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_done_s) begin
                    state_next_s = CHECK;
                end else if (rx_valid || pending_s) begin
                    state_next_s = RECV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (frame_done_s) begin
                    state_next_s = CHECK;
                end else if (timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RECV;
                end
            end
            CHECK: begin
                if (frame_ok_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: frame rejection in CHECK, opcode action decode in EXEC
    always_comb begin
        key_wr_s      = 1'b0;
        text_wr_s     = 1'b0;
        ld_req_s      = 1'b0;
        reply_s       = 1'b0;
        err_chk_s     = 1'b0;
        err_enc_s     = 1'b0;
        reply_frame_s = {FRAME_BITS{1'b0}};
        case (state_r)
            CHECK: begin
                if (!frame_ok_s) begin
                    err_chk_s = 1'b1;
                end else begin
                    err_chk_s = 1'b0;
                end
            end
            EXEC: begin
                case (op_s)
                    OP_KEY:  key_wr_s  = 1'b1;
                    OP_TEXT: text_wr_s = 1'b1;
                    OP_ENC: begin
                        if (busy_r) begin
                            err_enc_s = 1'b1;
                        end else begin
                            ld_req_s = 1'b1;
                        end
                    end
                    OP_RES: begin
                        reply_s       = 1'b1;
                        reply_frame_s = {op_s, result_fwd_s, op_s};
                    end
                    OP_RDKEY: begin
                        reply_s       = 1'b1;
                        reply_frame_s = {op_s, key_r, op_s};
                    end
                    OP_RDTXT: begin
                        reply_s       = 1'b1;
                        reply_frame_s = {op_s, text_r, op_s};
                    end
                    OP_TEST: begin
                        reply_s       = 1'b1;
                        reply_frame_s = TEST_PATTERN;
                    end
                    default: reply_s = 1'b0;
                endcase
            end
            default: reply_s = 1'b0;
        endcase
    end

    // Key and plaintext registers; updates apply even while the core is busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r  <= 128'd0;
            text_r <= 128'd0;
        end else begin
            if (key_wr_s) begin
                key_r <= payload_s;
            end else begin
                key_r <= key_r;
            end
            if (text_wr_s) begin
                text_r <= payload_s;
            end else begin
                text_r <= text_r;
            end
        end
    end

    // Result capture and in-flight flag, tracked in every FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= 128'd0;
            busy_r   <= 1'b0;
        end else begin
            if (aes_done) begin
                result_r <= aes_result;
            end else begin
                result_r <= result_r;
            end
            if (ld_req_s) begin
                busy_r <= 1'b1;
            end else if (aes_done) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Registered core load pulse, TX trigger and reply frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aes_ld_r   <= 1'b0;
            tx_send_r  <= 1'b0;
            tx_frame_r <= {FRAME_BITS{1'b0}};
        end else begin
            aes_ld_r  <= ld_req_s;
            tx_send_r <= reply_s;
            if (reply_s) begin
                tx_frame_r <= reply_frame_s;
            end else begin
                tx_frame_r <= tx_frame_r;
            end
        end
    end

    // Rejected-frame counter, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign key      = key_r;
    assign text     = text_r;
    assign aes_ld   = aes_ld_r;
    assign tx_frame = tx_frame_r;
    assign tx_send  = tx_send_r;
    assign busy     = busy_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_aes_uart_cmd_framer.sv
// Self-checking bench for aes_uart_cmd_framer: directed protocol scenarios
// plus a randomized frame sequence, checked against a frame-level model.
module tb_aes_uart_cmd_framer;

    localparam logic [7:0] OPA = 8'h41;
    localparam logic [7:0] OPC = 8'h43;
    localparam logic [7:0] OPD = 8'h44;
    localparam logic [7:0] OPE = 8'h45;
    localparam logic [7:0] OPR = 8'h40;
    localparam logic [7:0] OPK = 8'h61;
    localparam logic [7:0] OPT = 8'h62;
    localparam logic [143:0] PATTERN = 144'h313233343536373839303132333435363738;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] key;
    logic [127:0] text;
    logic         aes_ld;
    logic         aes_done;
    logic [127:0] aes_result;
    logic [143:0] tx_frame;
    logic         tx_send;
    logic         busy;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int tx_cnt = 0;
    int ld_cnt = 0;
    int tx_cyc = 0;
    int ld_cyc = 0;
    logic [143:0] tx_last = 144'd0;
    logic [127:0] ld_key = 128'd0;

    // frame-level reference model
    logic [127:0] m_key, m_text, m_res;
    logic         m_busy;
    int           m_err;

    aes_uart_cmd_framer #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .key        (key),
        .text       (text),
        .aes_ld     (aes_ld),
        .aes_done   (aes_done),
        .aes_result (aes_result),
        .tx_frame   (tx_frame),
        .tx_send    (tx_send),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            tx_cnt  = tx_cnt + 1;
            tx_last = tx_frame;
            tx_cyc  = cyc;
        end
        if (aes_ld === 1'b1) begin
            ld_cnt = ld_cnt + 1;
            ld_cyc = cyc;
            ld_key = key;
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = 128'd0; m_text = 128'd0; m_res = 128'd0; m_busy = 1'b0; m_err = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err = m_err + 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_cyc   = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [127:0] pl, input logic [7:0] tr);
        logic [143:0] f;
        f = {op, pl, tr};
        for (int i = 0; i < 18; i++) send_byte(f[143 - 8*i -: 8]);
    endtask

    task automatic pulse_done(input logic [127:0] v);
        aes_result = v;
        aes_done   = 1'b1;
        @(negedge clk);
        aes_done   = 1'b0;
        m_res  = v;
        m_busy = 1'b0;
    endtask

    // send one frame, predict its effect from the protocol rules, then check
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [127:0] pl,
                             input logic [7:0] tr, input logic bypass, input logic [127:0] bres);
        int tx0, ld0;
        logic exp_tx, exp_ld;
        logic [143:0] exp_f;
        tx0 = tx_cnt; ld0 = ld_cnt; exp_tx = 1'b0; exp_ld = 1'b0; exp_f = 144'd0;
        if (bypass) begin
            m_res = bres;
            m_busy = 1'b0;
        end
        if (op != tr || !(op inside {OPA, OPC, OPD, OPE, OPR, OPK, OPT})) begin
            model_err();
        end else begin
            case (op)
                OPC: m_key = pl;
                OPD: m_text = pl;
                OPE: if (m_busy) model_err(); else begin exp_ld = 1'b1; m_busy = 1'b1; end
                OPR: begin exp_tx = 1'b1; exp_f = {op, m_res, op}; end
                OPK: begin exp_tx = 1'b1; exp_f = {op, m_key, op}; end
                OPT: begin exp_tx = 1'b1; exp_f = {op, m_text, op}; end
                OPA: begin exp_tx = 1'b1; exp_f = PATTERN; end
                default: ;
            endcase
        end
        send_frame(op, pl, tr);
        if (bypass) begin
            @(negedge clk);
            aes_result = bres;
            aes_done   = 1'b1;
            @(negedge clk);
            aes_done   = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        #1;
        chk({tag, " tx_count"}, 144'(tx_cnt - tx0), 144'(exp_tx));
        chk({tag, " ld_count"}, 144'(ld_cnt - ld0), 144'(exp_ld));
        if (exp_tx) begin
            chk({tag, " tx_frame"}, tx_last, exp_f);
            chk({tag, " tx_latency"}, 144'(tx_cyc), 144'(rx_cyc + 3));
        end
        if (exp_ld) begin
            chk({tag, " ld_latency"}, 144'(ld_cyc), 144'(rx_cyc + 3));
            chk({tag, " ld_key"}, 144'(ld_key), 144'(m_key));
        end
        chk({tag, " key"}, 144'(key), 144'(m_key));
        chk({tag, " text"}, 144'(text), 144'(m_text));
        chk({tag, " busy"}, 144'(busy), 144'(m_busy));
        chk({tag, " err_cnt"}, 144'(err_cnt), 144'(m_err));
    endtask

    initial begin
        logic [7:0]   ops [8];
        logic [7:0]   op, tr;
        logic [127:0] pl, rv;
        int           e0, tx0;

        ops = '{OPA, OPC, OPD, OPE, OPR, OPK, OPT, 8'h5a};
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; aes_done = 1'b0; aes_result = 128'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset key", 144'(key), 144'd0);
        chk("reset text", 144'(text), 144'd0);
        chk("reset tx_frame", tx_frame, 144'd0);
        chk("reset pulses", 144'({aes_ld, tx_send, busy}), 144'd0);
        chk("reset err_cnt", 144'(err_cnt), 144'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: key load and read-back
        run_frame("t1_key", OPC, 128'h000102030405060708090a0b0c0d0e0f, OPC, 1'b0, 128'd0);
        run_frame("t1_rdkey", OPK, {$urandom, $urandom, $urandom, $urandom}, OPK, 1'b0, 128'd0);
        chk("t1 reply", tx_last, {OPK, 128'h000102030405060708090a0b0c0d0e0f, OPK});

        // 2: FIPS-197 vector through a modelled core
        run_frame("t2_key", OPC, 128'h2b7e151628aed2a6abf7158809cf4f3c, OPC, 1'b0, 128'd0);
        run_frame("t2_text", OPD, 128'h3243f6a8885a308d313198a2e0370734, OPD, 1'b0, 128'd0);
        run_frame("t2_enc", OPE, 128'd0, OPE, 1'b0, 128'd0);
        repeat (7) @(negedge clk);
        pulse_done(128'h3925841d02dc09fbdc118597196a0b32);
        #1 chk("t2 busy_clear", 144'(busy), 144'd0);
        run_frame("t2_res", OPR, 128'd0, OPR, 1'b0, 128'd0);
        chk("t2 payload", tx_last[135:8], 144'(128'h3925841d02dc09fbdc118597196a0b32));

        // 3: opcode/trailer mismatch
        run_frame("t3_bad", OPC, {$urandom, $urandom, $urandom, $urandom}, OPD, 1'b0, 128'd0);

        // 4: second encrypt while busy
        run_frame("t4_enc1", OPE, 128'd0, OPE, 1'b0, 128'd0);
        run_frame("t4_enc2", OPE, 128'd0, OPE, 1'b0, 128'd0);
        pulse_done({$urandom, $urandom, $urandom, $urandom});
        #1 chk("t4 busy_clear", 144'(busy), 144'd0);

        // randomized frame sequence
        for (int i = 0; i < 30; i++) begin
            if (m_busy && ($urandom_range(0, 1) == 0)) pulse_done({$urandom, $urandom, $urandom, $urandom});
            op = ops[$urandom_range(0, 7)];
            tr = ($urandom_range(0, 5) == 0) ? (op ^ 8'h01) : op;
            pl = {$urandom, $urandom, $urandom, $urandom};
            run_frame("rand", op, pl, tr, 1'b0, 128'd0);
        end
        if (m_busy) pulse_done({$urandom, $urandom, $urandom, $urandom});

        // back-to-back frames: next frame's first byte lands during CHECK
        pl = {$urandom, $urandom, $urandom, $urandom};
        tx0 = tx_cnt;
        send_frame(OPC, pl, OPC);
        send_frame(OPK, 128'd0, OPK);
        m_key = pl;
        repeat (5) @(negedge clk);
        #1;
        chk("b2b tx_count", 144'(tx_cnt - tx0), 144'd1);
        chk("b2b reply", tx_last, {OPK, pl, OPK});

        // result bypass: aes_done coincides with EXEC of "@"
        rv = {$urandom, $urandom, $urandom, $urandom};
        run_frame("bypass", OPR, 128'd0, OPR, 1'b1, rv);
        chk("bypass payload", tx_last[135:8], 144'(rv));

        // 5: partial frame followed by a long gap
        e0 = m_err;
        tx0 = tx_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h11);
        repeat (150) @(negedge clk);
        send_frame(OPT, {$urandom, $urandom, $urandom, $urandom}, OPT);
        repeat (5) @(negedge clk);
        #1;
        chk("t5 err_cnt", 144'(err_cnt), 144'(e0 + 1));
`ifdef AES_FRAMER_TIMEOUT_EN
        chk("t5 tx_count", 144'(tx_cnt - tx0), 144'd1);
        chk("t5 reply", tx_last, {OPT, m_text, OPT});
`else
        chk("t5 tx_count", 144'(tx_cnt - tx0), 144'd0);
`endif

        // resync by reset, then drive err_cnt into saturation
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst2 err_cnt", 144'(err_cnt), 144'd0);
        for (int i = 0; i < 254; i++) begin
            send_frame(OPC, 128'd0, OPD);
            repeat (2) @(negedge clk);
        end
        #1 chk("sat 254", 144'(err_cnt), 144'd254);
        send_frame(OPC, 128'd0, OPD);
        repeat (3) @(negedge clk);
        #1 chk("sat 255", 144'(err_cnt), 144'd255);
        send_frame(OPC, 128'd0, OPD);
        repeat (3) @(negedge clk);
        #1 chk("sat hold", 144'(err_cnt), 144'd255);

        // 6: reset in the middle of a key frame
        pl = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 9; i++) send_byte(({OPC, pl, OPC} >> (136 - 8*i)) & 144'hff);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("t6 key", 144'(key), 144'd0);
        chk("t6 err_cnt", 144'(err_cnt), 144'd0);
        chk("t6 busy", 144'(busy), 144'd0);
        run_frame("t6_test", OPA, {$urandom, $urandom, $urandom, $urandom}, OPA, 1'b0, 128'd0);
        chk("t6 pattern", tx_last, PATTERN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
